// File: rtl/noc_rx_fetch_if.sv
// Bus bundle for noc_rx_fetch: single-beat AXI read (AR/R) toward the NI
// plus the valid/ready receive port toward the core.
interface noc_rx_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int VC_W   = 2
);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic [VC_W-1:0]   rx_vc;

    modport master (
        output ar_valid, ar_addr, r_ready, rx_valid, rx_data, rx_vc,
        input  ar_ready, r_valid, r_data, r_resp, rx_ready
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready, rx_valid, rx_data, rx_vc,
        output ar_ready, r_valid, r_data, r_resp, rx_ready
    );
endinterface

// File: rtl/noc_rx_fetch.sv
// Tile receive engine: round-robin over NI rx IRQs, fetches one flit per grant
// with a single-beat AXI read and queues it, VC-tagged, for the core.
module noc_rx_fetch #(
    parameter int                N_VC         = 3,
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                FIFO_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RD_BASE_ADDR = 'h1000,
    parameter logic [ADDR_W-1:0] VC_STRIDE    = 'h8,
    localparam int               VC_W         = (N_VC > 1) ? $clog2(N_VC) : 1,
    localparam int               PTR_W        = $clog2(FIFO_DEPTH)
) (
    input  logic                clk_core,
    input  logic                arst_core,
    input  logic                en,
    input  logic [N_VC-1:0]     irq_rx,
    noc_rx_fetch_if.master      bus,
    output logic [PTR_W:0]      fifo_cnt,
    output logic [7:0]          err_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]      state;
    logic [VC_W-1:0] cur_vc;
    logic [VC_W-1:0] rr_ptr;
    logic [N_VC-1:0] holdoff;
    logic [N_VC-1:0] eligible;
    logic            grant_ok;
    logic [VC_W-1:0] grant_vc;
    logic [VC_W-1:0] next_rr;
    int              idx;

    logic [VC_W+DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   push;
    logic                   pop;
    logic                   r_done;
    logic                   issue;

    assign eligible = irq_rx & ~holdoff;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_ok = 1'b0;
        grant_vc = '0;
        idx      = 0;
        for (int i = 0; i < N_VC; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_VC) idx = idx - N_VC;
            if (!grant_ok && eligible[idx]) begin
                grant_ok = 1'b1;
                grant_vc = VC_W'(idx);
            end
        end
    end

    assign next_rr = (grant_vc == VC_W'(N_VC - 1)) ? '0 : grant_vc + 1'b1;

    // Space is reserved at issue time, so the later push can never overflow.
    assign issue  = (state == IDLE) && en && grant_ok &&
                    (fifo_cnt < (PTR_W+1)'(FIFO_DEPTH));
    assign r_done = (state == DATA) && bus.r_valid;
    assign push   = r_done && (bus.r_resp == 2'b00);
    assign pop    = bus.rx_valid && bus.rx_ready;

    assign bus.ar_valid = (state == ADDR);
    assign bus.r_ready  = (state == DATA);
    assign bus.ar_addr  = RD_BASE_ADDR + ADDR_W'(cur_vc) * VC_STRIDE;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_core) begin
        if (arst_core) begin
            state   <= IDLE;
            cur_vc  <= '0;
            rr_ptr  <= '0;
            holdoff <= '0;
            err_cnt <= '0;
        end else begin
            holdoff <= '0;
            case (state)
                IDLE: if (issue) begin
                    state  <= ADDR;
                    cur_vc <= grant_vc;
                    rr_ptr <= next_rr;
                end
                ADDR: if (bus.ar_ready) state <= DATA;
                DATA: if (bus.r_valid) begin
                    state <= IDLE;
                    // Mask the stale IRQ level for one cycle while the NI updates it.
                    holdoff[cur_vc] <= 1'b1;
                    if (bus.r_resp != 2'b00 && err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_core) begin
        if (arst_core) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk_core) begin
        if (push) mem[wr_ptr] <= {cur_vc, bus.r_data};
    end

    assign bus.rx_valid = (fifo_cnt != '0);
    assign bus.rx_data  = mem[rd_ptr][DATA_W-1:0];
    assign bus.rx_vc    = mem[rd_ptr][DATA_W +: VC_W];

endmodule
